// File: rtl/btn_defs.sv
`default_nettype none
// ============================================================================
//  Module      : btn_defs (package)
//  Description : Shared FSM state encodings, default timing constants and a
//                counter-width helper for the push-button event front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package btn_defs;

    // FSM states, visible to consumer blocks that decode press_active context
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } btn_state_e;

    // Default timing constants (in clock cycles)
    localparam int unsigned C_DEF_DEBOUNCE_CYCLES = 20;
    localparam int unsigned C_DEF_LONG_CYCLES     = 300;
    localparam int unsigned C_DEF_REPEAT_CYCLES   = 100;

    // Counter width for a threshold n: one spare bit above $clog2
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage : btn_defs
`default_nettype wire

// File: rtl/button_event_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : button_event_tx_if
//  Description : Bundle of button input, power gate and conditioned event
//                outputs. master = stimulus/consumer side, slave = front end.
//  Revision    : 1.0 - initial release
// ============================================================================
interface button_event_tx_if;
    logic power_on;
    logic btn_raw;
    logic btn_level;
    logic press_active;
    logic short_press;
    logic long_press;
    logic repeat_press;

    modport master (
        output power_on, btn_raw,
        input  btn_level, press_active, short_press, long_press, repeat_press
    );

    modport slave (
        input  power_on, btn_raw,
        output btn_level, press_active, short_press, long_press, repeat_press
    );
endinterface : button_event_tx_if
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Two-flop synchronizer followed by a consecutive-mismatch
//                debounce counter. btn_level only flips after the synchronized
//                input has disagreed with it for DEBOUNCE_CYCLES edges in a row.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
    import btn_defs::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = C_DEF_DEBOUNCE_CYCLES
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic btn_raw,
    output logic      btn_level
);

    localparam int unsigned          CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;

    // Synchronizer shift and debounce counter/level update
    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        level_d   = level_q;
        deb_cnt_d = '0;
        if (sync2_q != level_q) begin
            if (deb_cnt_q == CNT_LAST) begin
                level_d   = ~level_q;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    // State registers, cleared asynchronously so reset needs no clock
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            level_q   <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign btn_level = level_q;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/button_event_tx.sv
`default_nettype none
// ============================================================================
//  Module      : button_event_tx
//  Description : Conditions one raw push-button and emits registered,
//                single-cycle short / long / repeat press events. power_on=0
//                forces the press FSM idle so nothing is sent while off.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_event_tx
    import btn_defs::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = C_DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = C_DEF_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = C_DEF_REPEAT_CYCLES
) (
    input  wire logic            clk,
    input  wire logic            reset,
    button_event_tx_if.slave     bus
);

    localparam int unsigned       HOLD_W    = cnt_width(LONG_CYCLES);
    localparam int unsigned       REP_W     = cnt_width(REPEAT_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

    logic              btn_level;
    logic              btn_level_q;
    logic              level_rise;
    btn_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
    logic              short_press_q, short_press_d;
    logic              long_press_q, long_press_d;
    logic              repeat_press_q, repeat_press_d;
    logic              press_active_q, press_active_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (bus.btn_raw),
        .btn_level (btn_level)
    );

    // A press only starts on a genuine 0->1 transition of the clean level
    assign level_rise = btn_level & ~btn_level_q;

    // Next-state, hold/repeat counting and pulse decode
    always_comb begin
        state_d        = state_q;
        hold_cnt_d     = hold_cnt_q;
        rep_cnt_d      = rep_cnt_q;
        short_press_d  = 1'b0;
        long_press_d   = 1'b0;
        repeat_press_d = 1'b0;
        if (!bus.power_on) begin
            state_d    = ST_IDLE;
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (level_rise) begin
                        state_d    = ST_HELD;
                        hold_cnt_d = '0;
                    end
                end
                ST_HELD: begin
                    // release wins over reaching the long threshold
                    if (!btn_level) begin
                        short_press_d = 1'b1;
                        state_d       = ST_IDLE;
                        hold_cnt_d    = '0;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        long_press_d = 1'b1;
                        state_d      = ST_LONG;
                        hold_cnt_d   = '0;
                        rep_cnt_d    = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                ST_LONG: begin
                    if (!btn_level) begin
                        state_d   = ST_IDLE;
                        rep_cnt_d = '0;
                    end else if (REPEAT_CYCLES != 0) begin
                        if (rep_cnt_q == REP_LAST) begin
                            repeat_press_d = 1'b1;
                            rep_cnt_d      = '0;
                        end else begin
                            rep_cnt_d = rep_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = '0;
                    rep_cnt_d  = '0;
                end
            endcase
        end
        press_active_d = (state_d != ST_IDLE);
    end

    // FSM, counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_level_q    <= 1'b0;
            state_q        <= ST_IDLE;
            hold_cnt_q     <= '0;
            rep_cnt_q      <= '0;
            short_press_q  <= 1'b0;
            long_press_q   <= 1'b0;
            repeat_press_q <= 1'b0;
            press_active_q <= 1'b0;
        end else begin
            btn_level_q    <= btn_level;
            state_q        <= state_d;
            hold_cnt_q     <= hold_cnt_d;
            rep_cnt_q      <= rep_cnt_d;
            short_press_q  <= short_press_d;
            long_press_q   <= long_press_d;
            repeat_press_q <= repeat_press_d;
            press_active_q <= press_active_d;
        end
    end

    assign bus.btn_level    = btn_level;
    assign bus.press_active = press_active_q;
    assign bus.short_press  = short_press_q;
    assign bus.long_press   = long_press_q;
    assign bus.repeat_press = repeat_press_q;

endmodule : button_event_tx
`default_nettype wire

// File: tb/tb_button_event_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_event_tx
//  Description : Bench for button_event_tx. An edge-timestamp reference model
//                predicts every output each cycle; directed scenarios pin the
//                model with hand-derived latencies; a random phase follows.
//                A second instance is built with repeats disabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_event_tx;

    localparam int DEB = 4;
    localparam int LNG = 10;
    localparam int REP = 5;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic raw   = 1'b0;
    logic pwr   = 1'b1;
    bit   chk_en = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    button_event_tx_if bif ();
    button_event_tx_if bif0 ();

    assign bif.btn_raw   = raw;
    assign bif.power_on  = pwr;
    assign bif0.btn_raw  = raw;
    assign bif0.power_on = pwr;

    button_event_tx #(
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LNG),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    button_event_tx #(
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LNG),
        .REPEAT_CYCLES   (0)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bif0)
    );

    // ---------------- comparison helpers ----------------
    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %b expected %b", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // ---------------- reference model ----------------
    // The press is tracked by the edge number at which it started; every
    // event is derived from the age of the press at the current edge.
    bit m_raw_hist[$];
    bit m_sync_hist[$];
    bit m_level, m_level_q, m_active;
    bit m_short, m_long, m_rep;
    int m_edge, m_start;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_raw_hist  = '{1'b0, 1'b0};
            m_sync_hist = '{};
            m_level     = 1'b0;
            m_level_q   = 1'b0;
            m_active    = 1'b0;
            m_short     = 1'b0;
            m_long      = 1'b0;
            m_rep       = 1'b0;
            m_start     = 0;
        end else begin
            bit sync_now;
            bit lvl_new;
            bit all_diff;
            int age;
            m_edge++;
            // raw reaches the debouncer two edges after it was sampled
            sync_now = m_raw_hist[m_raw_hist.size() - 2];
            m_raw_hist.push_back(raw);
            if (m_raw_hist.size() > 4) void'(m_raw_hist.pop_front());
            m_sync_hist.push_back(sync_now);
            if (m_sync_hist.size() > DEB) void'(m_sync_hist.pop_front());
            // level flips when the last DEB synchronized samples all disagree
            lvl_new = m_level;
            if (m_sync_hist.size() == DEB) begin
                all_diff = 1'b1;
                foreach (m_sync_hist[i]) if (m_sync_hist[i] == m_level) all_diff = 1'b0;
                if (all_diff) lvl_new = ~m_level;
            end
            m_short = 1'b0;
            m_long  = 1'b0;
            m_rep   = 1'b0;
            if (!pwr) begin
                m_active = 1'b0;
            end else if (!m_active) begin
                if (m_level && !m_level_q) begin
                    m_active = 1'b1;
                    m_start  = m_edge;
                end
            end else begin
                age = m_edge - m_start;
                if (!m_level) begin
                    m_short  = (age <= LNG);
                    m_active = 1'b0;
                end else if (age == LNG) begin
                    m_long = 1'b1;
                end else if (age > LNG && ((age - LNG) % REP) == 0) begin
                    m_rep = 1'b1;
                end
            end
            m_level_q = m_level;
            m_level   = lvl_new;
        end
    end

    // ---------------- per-cycle compare + event logging ----------------
    int cyc0;
    int n_short, n_long, n_rep, n_lvl, n_act, n0_long, n0_rep;
    int short_at, long_at, rep_first, rep_last, lvl_rise_at;

    task automatic clr();
        cyc0 = cyc;
        n_short = 0; n_long = 0; n_rep = 0; n_lvl = 0; n_act = 0;
        n0_long = 0; n0_rep = 0;
        short_at = -1; long_at = -1; rep_first = -1; rep_last = -1; lvl_rise_at = -1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("level",         bif.btn_level,     m_level);
            chk("press_active",  bif.press_active,  m_active);
            chk("short_press",   bif.short_press,   m_short);
            chk("long_press",    bif.long_press,    m_long);
            chk("repeat_press",  bif.repeat_press,  m_rep);
            chk("r0_level",      bif0.btn_level,    m_level);
            chk("r0_active",     bif0.press_active, m_active);
            chk("r0_short",      bif0.short_press,  m_short);
            chk("r0_long",       bif0.long_press,   m_long);
            chk("r0_repeat",     bif0.repeat_press, 1'b0);
            if (bif.btn_level) begin
                if (n_lvl == 0) lvl_rise_at = cyc - cyc0;
                n_lvl++;
            end
            if (bif.press_active) n_act++;
            if (bif.short_press) begin n_short++; short_at = cyc - cyc0; end
            if (bif.long_press)  begin n_long++;  long_at  = cyc - cyc0; end
            if (bif.repeat_press) begin
                n_rep++;
                if (n_rep == 1) rep_first = cyc - cyc0;
                rep_last = cyc - cyc0;
            end
            if (bif0.long_press)   n0_long++;
            if (bif0.repeat_press) n0_rep++;
        end
    end

    task automatic press(input int hold, input int gap);
        clr();
        raw = 1'b1;
        repeat (hold) @(negedge clk);
        raw = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clr();
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_level",  bif.btn_level,    1'b0);
        chk("rst_active", bif.press_active, 1'b0);
        chk("rst_short",  bif.short_press,  1'b0);
        chk("rst_long",   bif.long_press,   1'b0);
        chk("rst_repeat", bif.repeat_press, 1'b0);
        @(negedge clk);
        reset  = 1'b1;
        chk_en = 1'b1;
        repeat (5) @(negedge clk);

        // glitch shorter than the debounce window
        press(3, 20);
        chk_int("glitch_level_cycles", n_lvl, 0);
        chk_int("glitch_active_cycles", n_act, 0);
        chk_int("glitch_events", n_short + n_long + n_rep, 0);

        // short press
        press(8, 25);
        chk_int("short_level_rise", lvl_rise_at, 6);
        chk_int("short_count", n_short, 1);
        chk_int("short_at", short_at, 15);
        chk_int("short_no_long", n_long, 0);

        // long press with repeats
        press(40, 25);
        chk_int("long_count", n_long, 1);
        chk_int("long_at", long_at, 17);
        chk_int("rep_count", n_rep, 5);
        chk_int("rep_first", rep_first, 22);
        chk_int("rep_last", rep_last, 42);
        chk_int("long_no_short", n_short, 0);
        chk_int("r0_long_count", n0_long, 1);
        chk_int("r0_rep_count", n0_rep, 0);

        // power dropped while HELD
        clr();
        raw = 1'b1;
        repeat (10) @(negedge clk);
        chk("pwr_held_active", bif.press_active, 1'b1);
        pwr = 1'b0;
        @(negedge clk);
        chk("pwr_drop_active", bif.press_active, 1'b0);
        repeat (3) @(negedge clk);
        raw = 1'b0;
        repeat (20) @(negedge clk);
        pwr = 1'b1;
        chk_int("pwr_drop_short", n_short, 0);

        // pressed while off, powered up while still held
        clr();
        pwr = 1'b0;
        raw = 1'b1;
        repeat (15) @(negedge clk);
        pwr = 1'b1;
        repeat (15) @(negedge clk);
        raw = 1'b0;
        repeat (20) @(negedge clk);
        chk_int("pwr_up_events", n_short + n_long + n_rep, 0);
        chk_int("pwr_up_active", n_act, 0);
        press(8, 25);
        chk_int("repress_short", n_short, 1);

        // reset in the middle of LONG, released with the button held
        clr();
        raw = 1'b1;
        repeat (25) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_level",  bif.btn_level,    1'b0);
        chk("midrst_active", bif.press_active, 1'b0);
        chk("midrst_repeat", bif.repeat_press, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        clr();
        repeat (25) @(negedge clk);
        chk_int("rst_long_at", long_at, 17);
        chk_int("rst_long_count", n_long, 1);
        raw = 1'b0;
        repeat (30) @(negedge clk);

        // randomized presses, power flicker and occasional resets
        for (int it = 0; it < 80; it++) begin
            int hold_len;
            int gap_len;
            hold_len = int'($urandom_range(1, 45));
            gap_len  = int'($urandom_range(1, 30));
            pwr = ($urandom_range(0, 9) != 0);
            raw = 1'b1;
            for (int k = 0; k < hold_len; k++) begin
                if ($urandom_range(0, 29) == 0) pwr = ~pwr;
                @(negedge clk);
            end
            raw = 1'b0;
            if ($urandom_range(0, 19) == 0) begin
                #2 reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
            end
            for (int k = 0; k < gap_len; k++) begin
                if ($urandom_range(0, 29) == 0) pwr = ~pwr;
                @(negedge clk);
            end
            pwr = 1'b1;
        end
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_button_event_tx
`default_nettype wire
